// File: rtl/creek_pause_ctrl_if.sv
// rtl/creek_pause_ctrl_if.sv - run-control / issue handshake bundle for creek_pause_ctrl
//
// Purpose: groups the control-adapter signals and the instruction-issue
// handshake that creek_pause_ctrl sits between.
//
// Signals:
//   pause_n       adapter -> ctrl   0 requests a pause, 1 allows free-run
//   resume        adapter -> ctrl   single-cycle pulse, leaves WAIT
//   waiting       ctrl -> adapter   1 exactly while the core is halted and drained
//   instr_valid   issue -> ctrl     an instruction is presented
//   instr_halt    issue -> ctrl     presented instruction is a halt
//   instr_ready   ctrl -> issue     presented instruction is accepted this cycle
//   retire        issue -> ctrl     single-cycle pulse, one in-flight instruction done
//   inflight      ctrl -> observers issued-but-unretired count
//   underflow_err ctrl -> observers sticky retire-without-inflight flag
//
// Modports:
//   master  the adapter/issue side that drives requests
//   slave   the run-control block itself

interface creek_pause_ctrl_if #(
   parameter int CNT_WIDTH = 4
);
   logic                 pause_n;
   logic                 resume;
   logic                 waiting;
   logic                 instr_valid;
   logic                 instr_halt;
   logic                 instr_ready;
   logic                 retire;
   logic [CNT_WIDTH-1:0] inflight;
   logic                 underflow_err;

   modport master (
      output pause_n,
      output resume,
      output instr_valid,
      output instr_halt,
      output retire,
      input  waiting,
      input  instr_ready,
      input  inflight,
      input  underflow_err
   );

   modport slave (
      input  pause_n,
      input  resume,
      input  instr_valid,
      input  instr_halt,
      input  retire,
      output waiting,
      output instr_ready,
      output inflight,
      output underflow_err
   );
endinterface

// File: rtl/creek_pause_ctrl.sv
// rtl/creek_pause_ctrl.sv - run-control stage between the control adapter and instruction issue
//
// Purpose: gates instruction issue according to the adapter's pause_n level
// and resume pulse, counts issued-but-unretired instructions, and reports
// waiting only once the core has fully drained. Supports free-run, pause,
// single-step and a software halt instruction.
//
// Parameters:
//   MAX_INFLIGHT  issue stalls once this many instructions are in flight
//   CNT_WIDTH     width of the in-flight counter (2**CNT_WIDTH > MAX_INFLIGHT)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      creek_pause_ctrl_if.slave: pause_n, resume, instr_valid,
//            instr_halt, retire in; instr_ready (combinational), waiting,
//            inflight, underflow_err (registered) out

module creek_pause_ctrl #(
   parameter int MAX_INFLIGHT = 8,
   parameter int CNT_WIDTH    = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   creek_pause_ctrl_if.slave       bus
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_INFLIGHT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WAIT  = 2'd2,
      ST_STEP  = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] inflight_q;
   logic                 waiting_q;
   logic                 underflow_q;

   logic                 below_max;
   logic                 instr_ready;
   logic                 accept;
   logic                 issue;
   logic                 halt_take;

   assign below_max = (inflight_q < MAX_CNT);

   // Ready depends only on registered state and pause_n, never on
   // instr_valid, so the accept path below has no combinational loop.
   always_comb begin
      instr_ready = 1'b0;
      case (state_q)
         ST_RUN:   instr_ready = bus.pause_n && below_max;
         ST_STEP:  instr_ready = below_max;
         default:  instr_ready = 1'b0;
      endcase
      // The async reset already forces WAIT; this just keeps ready low
      // for the whole reset window regardless of state-register timing.
      if (!reset_n) begin
         instr_ready = 1'b0;
      end
   end

   assign accept    = bus.instr_valid && instr_ready;
   assign issue     = accept && !bus.instr_halt;
   assign halt_take = accept && bus.instr_halt;

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RUN: begin
            // A halt and a pause both lead to DRAIN; resume has no effect here.
            if (halt_take || !bus.pause_n) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Only the registered count matters: a retire this cycle is
            // still in flight, so WAIT is reached one edge after it lands.
            if (inflight_q == CNT_ZERO) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.resume) begin
               state_nxt = bus.pause_n ? ST_RUN : ST_STEP;
            end
         end
         ST_STEP: begin
            // One instruction (normal or halt) per step.
            if (accept) begin
               state_nxt = ST_DRAIN;
            end
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   // State register. waiting is loaded from the next state so it is high
   // in exactly the cycles the state register holds WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_WAIT;
         waiting_q <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         waiting_q <= (state_nxt == ST_WAIT);
      end
   end

   // In-flight accounting. Issue and retire together cancel out, including
   // at zero, where that pair is legal and does not count as an underflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q  <= CNT_ZERO;
         underflow_q <= 1'b0;
      end else begin
         if (issue && !bus.retire) begin
            inflight_q <= inflight_q + CNT_ONE;
         end else if (!issue && bus.retire) begin
            if (inflight_q == CNT_ZERO) begin
               underflow_q <= 1'b1;
            end else begin
               inflight_q <= inflight_q - CNT_ONE;
            end
         end
      end
   end

   assign bus.instr_ready   = instr_ready;
   assign bus.waiting       = waiting_q;
   assign bus.inflight      = inflight_q;
   assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_creek_pause_ctrl.sv
// tb/tb_creek_pause_ctrl.sv - directed self-checking bench for creek_pause_ctrl

module tb_creek_pause_ctrl;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   creek_pause_ctrl_if #(.CNT_WIDTH(4)) bus ();

   creek_pause_ctrl #(
      .MAX_INFLIGHT (8),
      .CNT_WIDTH    (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.pause_n     = 1'b0;
      bus.resume      = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr_halt  = 1'b0;
      bus.retire      = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      clear_inputs();
      cyc();
      reset_n = 1'b1;
      #1;
   endtask

   task automatic go_run();
      bus.pause_n = 1'b1;
      bus.resume  = 1'b1;
      cyc();
      bus.resume  = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      n_checks++; if (bus.waiting !== 1'b1) begin n_fail++; $display("FAIL reset_waiting: got %b expected 1", bus.waiting); end
      n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d expected 0", bus.inflight); end
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.instr_ready); end
      n_checks++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", bus.underflow_err); end
   endtask

   task automatic test_reset_mid_run();
      apply_reset();
      go_run();
      bus.instr_valid = 1'b1;
      repeat (3) cyc();
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.inflight !== 4'd3) begin n_fail++; $display("FAIL midrst_pre_inflight: got %0d expected 3", bus.inflight); end
      // Assert reset between edges and look before the next edge.
      #1;
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.waiting !== 1'b1) begin n_fail++; $display("FAIL midrst_waiting: got %b expected 1", bus.waiting); end
      n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL midrst_inflight: got %0d expected 0", bus.inflight); end
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", bus.instr_ready); end
      n_checks++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL midrst_underflow: got %b expected 0", bus.underflow_err); end
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic test_free_run();
      apply_reset();
      go_run();
      n_checks++; if (bus.waiting !== 1'b0) begin n_fail++; $display("FAIL run_waiting: got %b expected 0", bus.waiting); end
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b expected 1", bus.instr_ready); end
      bus.instr_valid = 1'b1;
      repeat (8) cyc();
      #1;
      n_checks++; if (bus.inflight !== 4'd8) begin n_fail++; $display("FAIL run_full_inflight: got %0d expected 8", bus.inflight); end
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL run_full_ready: got %b expected 0", bus.instr_ready); end
      bus.retire = 1'b1;
      cyc();
      bus.retire = 1'b0;
      #1;
      n_checks++; if (bus.inflight !== 4'd7) begin n_fail++; $display("FAIL run_retire_inflight: got %0d expected 7", bus.inflight); end
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL run_retire_ready: got %b expected 1", bus.instr_ready); end
      bus.instr_valid = 1'b0;
   endtask

   task automatic test_pause_drain();
      apply_reset();
      go_run();
      bus.instr_valid = 1'b1;
      repeat (2) cyc();
      bus.instr_valid = 1'b0;
      bus.pause_n     = 1'b0;
      #1;
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_same_cycle: got %b expected 0", bus.instr_ready); end
      n_checks++; if (bus.inflight !== 4'd2) begin n_fail++; $display("FAIL drain_inflight: got %0d expected 2", bus.inflight); end
      cyc();
      bus.retire = 1'b1;
      repeat (2) cyc();
      bus.retire = 1'b0;
      n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL drain_empty_inflight: got %0d expected 0", bus.inflight); end
      n_checks++; if (bus.waiting !== 1'b0) begin n_fail++; $display("FAIL drain_waiting_early: got %b expected 0", bus.waiting); end
      cyc();
      n_checks++; if (bus.waiting !== 1'b1) begin n_fail++; $display("FAIL drain_waiting: got %b expected 1", bus.waiting); end
   endtask

   task automatic test_single_step();
      apply_reset();
      bus.pause_n = 1'b0;
      bus.resume  = 1'b1;
      cyc();
      bus.resume  = 1'b0;
      #1;
      n_checks++; if (bus.waiting !== 1'b0) begin n_fail++; $display("FAIL step_waiting: got %b expected 0", bus.waiting); end
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL step_ready: got %b expected 1", bus.instr_ready); end
      bus.instr_valid = 1'b1;
      cyc();
      n_checks++; if (bus.inflight !== 4'd1) begin n_fail++; $display("FAIL step_one_inflight: got %0d expected 1", bus.inflight); end
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL step_second_stalled: got %b expected 0", bus.instr_ready); end
      cyc();
      n_checks++; if (bus.inflight !== 4'd1) begin n_fail++; $display("FAIL step_still_one: got %0d expected 1", bus.inflight); end
      bus.instr_valid = 1'b0;
      bus.retire      = 1'b1;
      cyc();
      bus.retire      = 1'b0;
      n_checks++; if (bus.waiting !== 1'b0) begin n_fail++; $display("FAIL step_waiting_early: got %b expected 0", bus.waiting); end
      cyc();
      n_checks++; if (bus.waiting !== 1'b1) begin n_fail++; $display("FAIL step_waiting_again: got %b expected 1", bus.waiting); end
   endtask

   task automatic test_halt();
      apply_reset();
      go_run();
      bus.instr_valid = 1'b1;
      bus.instr_halt  = 1'b1;
      #1;
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL halt_ready: got %b expected 1", bus.instr_ready); end
      cyc();
      bus.instr_valid = 1'b0;
      bus.instr_halt  = 1'b0;
      #1;
      n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL halt_inflight: got %0d expected 0", bus.inflight); end
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL halt_drain_ready: got %b expected 0", bus.instr_ready); end
      n_checks++; if (bus.waiting !== 1'b0) begin n_fail++; $display("FAIL halt_waiting_early: got %b expected 0", bus.waiting); end
      cyc();
      n_checks++; if (bus.waiting !== 1'b1) begin n_fail++; $display("FAIL halt_waiting: got %b expected 1", bus.waiting); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      go_run();
      bus.instr_valid = 1'b1;
      repeat (4) cyc();
      bus.retire = 1'b1;
      cyc();
      bus.retire      = 1'b0;
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.inflight !== 4'd4) begin n_fail++; $display("FAIL b2b_inflight: got %0d expected 4", bus.inflight); end
      n_checks++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL b2b_underflow: got %b expected 0", bus.underflow_err); end
   endtask

   task automatic test_underflow();
      apply_reset();
      go_run();
      bus.retire = 1'b1;
      cyc();
      bus.retire = 1'b0;
      n_checks++; if (bus.underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_flag: got %b expected 1", bus.underflow_err); end
      n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL uf_inflight: got %0d expected 0", bus.inflight); end
      bus.instr_valid = 1'b1;
      bus.retire      = 1'b1;
      cyc();
      bus.instr_valid = 1'b0;
      bus.retire      = 1'b0;
      n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL uf_pair_at_zero: got %0d expected 0", bus.inflight); end
      cyc();
      n_checks++; if (bus.underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", bus.underflow_err); end
   endtask

   task automatic test_resume_ignored();
      apply_reset();
      go_run();
      bus.resume = 1'b1;
      cyc();
      bus.resume = 1'b0;
      n_checks++; if (bus.waiting !== 1'b0) begin n_fail++; $display("FAIL rsm_run_waiting: got %b expected 0", bus.waiting); end
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rsm_run_ready: got %b expected 1", bus.instr_ready); end
      apply_reset();
      bus.pause_n = 1'b1;
      repeat (2) cyc();
      n_checks++; if (bus.waiting !== 1'b1) begin n_fail++; $display("FAIL wait_no_resume: got %b expected 1", bus.waiting); end
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready: got %b expected 0", bus.instr_ready); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      clear_inputs();
      repeat (2) cyc();
      test_reset();
      reset_n = 1'b1;
      cyc();
      test_free_run();
      test_reset_mid_run();
      test_pause_drain();
      test_single_step();
      test_halt();
      test_back_to_back();
      test_underflow();
      test_resume_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/creek_pause_ctrl.md
Name: creek_pause_ctrl

Overview:
Run-control stage between the processor's Avalon control adapter and the instruction issue unit.
- Consumes the adapter's pause_n level and resume pulse, and produces the waiting status that the adapter reports back.
- Gates instruction issue and tracks in-flight instructions, so waiting asserts only once the core is fully drained.
- Supports free-run, pause, single-step and a software halt instruction.

Parameters:
MAX_INFLIGHT, 8, maximum number of issued-but-unretired instructions; issue stalls at this count.
CNT_WIDTH, 4, width of the in-flight counter; must satisfy 2^CNT_WIDTH > MAX_INFLIGHT.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
pause_n  input  1  level from the control adapter; 0 requests a pause, 1 allows free-run.
resume  input  1  single-cycle pulse from the control adapter; leaves the WAIT state.
instr_valid  input  1  issue unit presents an instruction.
instr_halt  input  1  presented instruction is a halt; qualified by instr_valid.
instr_ready  output  1  combinational; instruction is accepted when instr_valid && instr_ready.
retire  input  1  single-cycle pulse; one in-flight instruction completed.
waiting  output  1  registered; 1 exactly when the state is WAIT.
inflight  output  CNT_WIDTH  registered current in-flight count.
underflow_err  output  1  sticky; set when retire arrives while inflight == 0.

Behaviour:
- Reset (async, reset_n = 0):
  - state = WAIT, waiting = 1, inflight = 0, underflow_err = 0.
  - instr_ready = 0 while in reset.
  - Reset asserted mid-operation discards all in-flight accounting.
- Handshake:
  - accept = instr_valid && instr_ready.
  - issue = accept && !instr_halt.
  - halt_take = accept && instr_halt.
  - A halt instruction is consumed but never counted as in flight.
- Counter:
  - issue alone: +1. retire alone: −1. Both in the same cycle: unchanged.
  - retire with inflight == 0 (and no issue that cycle): count stays 0, underflow_err set; it clears only on reset.
  - A simultaneous issue and retire at count 0 is legal and leaves the count at 0.
- States:
  - RUN:
    - instr_ready = pause_n && (inflight < MAX_INFLIGHT).
    - On halt_take or pause_n = 0, go to DRAIN. halt_take has priority; the outcome is the same.
    - resume is ignored.
  - DRAIN:
    - instr_ready = 0.
    - Go to WAIT in the cycle after the registered inflight is 0 with no retire pending. Concretely: if inflight == 0 at the clock edge, next state is WAIT.
    - resume and pause_n are ignored.
  - WAIT:
    - instr_ready = 0, waiting = 1.
    - On resume: pause_n = 1 → RUN; pause_n = 0 → STEP.
    - Without resume, stay in WAIT, even if pause_n rises.
  - STEP:
    - instr_ready = (inflight < MAX_INFLIGHT).
    - On the first accept (normal or halt), go to DRAIN.
    - pause_n and resume are ignored.
- waiting is registered from the next state, so it is 1 in the same cycle the state register holds WAIT. Latency from the last retire to waiting = 1 is 2 clocks (counter update, then state update).
- Entry latency from pause_n falling in RUN:
  - instr_ready drops combinationally in the same cycle.
  - The DRAIN state is entered on the next edge.
- The state encoding must be one-hot or binary with a default branch to WAIT for unreachable codes.

Test Plan:
- Reset: assert reset_n = 0 mid-run with inflight = 3 → waiting = 1, inflight = 0, instr_ready = 0, underflow_err = 0, asynchronously, before the next edge.
- Free run: from WAIT, pause_n = 1, resume pulse → RUN next cycle. Issue 8 back-to-back with no retire → inflight = 8, instr_ready = 0 on the 9th request. One retire → instr_ready = 1 the next cycle.
- Pause drain: in RUN with inflight = 2, drop pause_n → instr_ready = 0 same cycle, state DRAIN. Retire, retire → inflight = 0; waiting = 1 exactly 2 cycles after the second retire.
- Single step: in WAIT with pause_n = 0, resume → STEP. Exactly one instruction accepted (a second instr_valid is stalled). After its retire → waiting = 1 again.
- Halt instruction: in RUN, present instr_halt = 1 → accepted in 1 cycle, inflight unchanged, DRAIN. With inflight = 0 → waiting = 1 next cycle, even though pause_n = 1.
- Simultaneous/edge cases:
  - issue + retire in the same cycle at inflight = 4 → inflight stays 4.
  - retire at inflight = 0 → underflow_err = 1, inflight stays 0.
  - resume pulse in RUN → no state change.
